boton_eventos: RTL
==================

# boton_eventos

Press-event classifier placed directly downstream of the button debouncer. It takes the clean, debounced button level and turns it into single-cycle event pulses: press, release, short press, long press and auto-repeat. Game and menu logic consume these pulses instead of raw levels. Timing is counted in `clk` cycles, the same time base as the debouncer (1 cycle = 1 ms in the target build).

## Interface
- `LONG_TIME`, default 2000: hold length in cycles that classifies a press as long; legal range ≥ 2.
- `REPEAT_TIME`, default 250: period in cycles of repeat pulses after a long press; legal range ≥ 1.
- `REPEAT_EN`, default 1: 1 enables auto-repeat; 0 forces `pulse_repeat` to 0.
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `btn_in`  input  1  debounced button level from the debouncer, synchronous to `clk`; 1 = pressed.
- `pulse_press`  output  1  one-cycle pulse on each press.
- `pulse_release`  output  1  one-cycle pulse on each release.
- `pulse_short`  output  1  one-cycle pulse on release of a press held < `LONG_TIME`.
- `pulse_long`  output  1  one-cycle pulse when a hold reaches `LONG_TIME`.
- `pulse_repeat`  output  1  one-cycle pulse every `REPEAT_TIME` cycles of hold after the long pulse.
- `held`  output  1  registered pressed level: 1 in states SHORT and LONG.

## Operation
- **Input handling:** `btn_in` is registered into `btn_d` (reset 0).
  - Rise = `btn_in & ~btn_d`.
  - Fall = `~btn_in & btn_d`.
- **Hold count:** N = number of consecutive rising edges at which `btn_in` was sampled 1.
- **State machine:** IDLE, SHORT, LONG.
  - IDLE, on rise → SHORT. Assert `pulse_press`. Load `hold_cnt` = 1.
  - SHORT, `btn_in` = 1 → increment `hold_cnt`. When the incremented value equals `LONG_TIME` → LONG, assert `pulse_long`, clear `rep_cnt`.
  - SHORT, `btn_in` = 0 → IDLE. Assert `pulse_release` and `pulse_short`.
  - LONG, `btn_in` = 1 → increment `rep_cnt`. When it reaches `REPEAT_TIME`, clear it to 0 and assert `pulse_repeat` (if `REPEAT_EN`).
  - LONG, `btn_in` = 0 → IDLE. Assert `pulse_release` only; never `pulse_short`.
- **Counter widths:**
  - `hold_cnt` is `$clog2(LONG_TIME+1)` bits. It is frozen in LONG, so it never overflows.
  - `rep_cnt` is `$clog2(REPEAT_TIME+1)` bits. It wraps only through the explicit clear.
- **Exclusivity:** at most one of press, release or long is asserted in any cycle. `pulse_short` always coincides with `pulse_release`.
- **Unlimited hold:** a hold in LONG produces repeats indefinitely; there is no timeout.
- **Reset:**
  - State IDLE; `btn_d`, `hold_cnt`, `rep_cnt` all 0.
  - Every output reads 0 while `rst_n` = 0.
  - Asserting reset mid-hold aborts the press silently: no release or short pulse is emitted.
- **Pressed at reset release:** if `btn_in` = 1 when `rst_n` deasserts, the first clock sees a rise and emits `pulse_press`; the press is then handled normally.

## Timing
- Outputs are fully registered; no combinational path from `btn_in` to any output.
- **Press:** `btn_in` sampled 1 at edge k (0 at edge k-1) → `pulse_press` high for the one cycle after edge k.
- **Long:** N reaches `LONG_TIME` at edge k → `pulse_long` high for the one cycle after edge k.
- **Repeat:** held N = `LONG_TIME` + m·`REPEAT_TIME` (m ≥ 1) → `pulse_repeat` high for the one cycle after that edge.
- **Release:** `btn_in` sampled 0 at edge k after N highs → `pulse_release` high for the one cycle after edge k; `pulse_short` is also high if N < `LONG_TIME`.
- **Boundary N = `LONG_TIME` − 1:** release at the next edge → short press.
- **Boundary N = `LONG_TIME`:** release → long press, with no short pulse.
- **Minimum press:** a 1-cycle press (N = 1) gives press, then release and short on consecutive cycles.
- **`held`:** rises with `pulse_press` and falls with `pulse_release`.

## Test plan
All scenarios use `LONG_TIME` = 8, `REPEAT_TIME` = 3, `REPEAT_EN` = 1.
- **Reset state:** `rst_n` = 0 with `btn_in` toggling → every output stays 0.
  - Release `rst_n` with `btn_in` = 1 → `pulse_press` fires once, one cycle later.
- **Short press:** hold `btn_in` for 5 cycles → press pulse, then `held` = 1 for 5 cycles, then release and short pulses together in one cycle; no long pulse.
- **Long boundary, N = 7:** hold 7 cycles → short pulse.
- **Long boundary, N = 8:** hold 8 cycles → `pulse_long` one cycle after the 8th high sample, then release with no short pulse.
- **Repeat:** hold 20 cycles → long pulse after N = 8, repeat pulses after N = 11, 14, 17 and 20, then one release pulse.
  - Rerun with `REPEAT_EN` = 0 → no repeat pulses.
- **Reset mid-hold and 1-cycle press:**
  - Assert `rst_n` = 0 at N = 5 → all outputs 0 immediately, no release pulse.
  - Apply a 1-cycle `btn_in` pulse → press, then release and short on consecutive cycles.

Source files
------------

// File: rtl/boton_eventos.sv
// Press-event classifier: turns the debounced button level into single-cycle
// press, release, short, long and auto-repeat pulses.
module boton_eventos #(
   parameter int unsigned LONG_TIME   = 2000,
   parameter int unsigned REPEAT_TIME = 250,
   parameter bit          REPEAT_EN   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic pulse_press,
   output logic pulse_release,
   output logic pulse_short,
   output logic pulse_long,
   output logic pulse_repeat,
   output logic held
);

   localparam int unsigned HOLD_W = $clog2(LONG_TIME + 1);
   localparam int unsigned REP_W  = $clog2(REPEAT_TIME + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHORT = 2'd1,
      S_LONG  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              btn_d;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic [HOLD_W-1:0] hold_inc;
   logic [REP_W-1:0]  rep_cnt;
   logic [REP_W-1:0]  rep_nxt;
   logic [REP_W-1:0]  rep_inc;
   logic              rise;
   logic              long_hit;
   logic              rep_hit;
   logic              press_nxt;
   logic              release_nxt;
   logic              short_nxt;
   logic              long_nxt;
   logic              repeat_nxt;
   logic              held_nxt;

   assign rise     = btn_in & ~btn_d;
   assign hold_inc = hold_cnt + HOLD_W'(1);
   assign rep_inc  = rep_cnt + REP_W'(1);
   assign long_hit = (hold_inc == HOLD_W'(LONG_TIME));
   assign rep_hit  = (rep_inc == REP_W'(REPEAT_TIME));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (rise) state_nxt = S_SHORT;
         end
         S_SHORT: begin
            if (!btn_in)       state_nxt = S_IDLE;
            else if (long_hit) state_nxt = S_LONG;
         end
         S_LONG: begin
            if (!btn_in) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Event decode and counter updates; hold_cnt freezes once LONG is reached
   always_comb begin
      hold_nxt    = hold_cnt;
      rep_nxt     = rep_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      short_nxt   = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (rise) begin
               press_nxt = 1'b1;
               hold_nxt  = HOLD_W'(1);
            end
         end
         S_SHORT: begin
            if (btn_in) begin
               hold_nxt = hold_inc;
               if (long_hit) begin
                  long_nxt = 1'b1;
                  rep_nxt  = '0;
               end
            end else begin
               release_nxt = 1'b1;
               short_nxt   = 1'b1;
            end
         end
         S_LONG: begin
            if (btn_in) begin
               if (rep_hit) begin
                  rep_nxt    = '0;
                  repeat_nxt = REPEAT_EN;
               end else begin
                  rep_nxt = rep_inc;
               end
            end else begin
               release_nxt = 1'b1;
            end
         end
         default: ;
      endcase
      held_nxt = (state_nxt != S_IDLE);
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_d         <= 1'b0;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         pulse_press   <= 1'b0;
         pulse_release <= 1'b0;
         pulse_short   <= 1'b0;
         pulse_long    <= 1'b0;
         pulse_repeat  <= 1'b0;
         held          <= 1'b0;
      end else begin
         btn_d         <= btn_in;
         hold_cnt      <= hold_nxt;
         rep_cnt       <= rep_nxt;
         pulse_press   <= press_nxt;
         pulse_release <= release_nxt;
         pulse_short   <= short_nxt;
         pulse_long    <= long_nxt;
         pulse_repeat  <= repeat_nxt;
         held          <= held_nxt;
      end
   end

endmodule
